mul_share_arb: RTL and testbench
================================

Name: mul_share_arb

Overview:
- Shares one unsigned 8x8 multiplier between two requesters, A and B.
- Each requester has a valid/ready issue port and a response strobe.
- Round-robin arbitration issues at most one op per cycle into a LAT-stage registered multiply pipeline.
- Sits in front of the team's shared multiplier datapath. It replaces the static operand select with dynamic scheduling, and keeps per-requester issue statistics.

Parameters:
- LAT, 2, pipeline depth from issue handshake to response strobe, in clock edges (legal 1..4).
- CW, 16, width of the per-requester saturating issue counters.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active high
- en  input  1  arbiter enable; 0 blocks new grants
- a_valid  input  1  requester A has an op
- a_ready  output  1  A op accepted this cycle
- a_x  input  8  A operand x
- a_y  input  8  A operand y
- b_valid  input  1  requester B has an op
- b_ready  output  1  B op accepted this cycle
- b_x  input  8  B operand x
- b_y  input  8  B operand y
- rsp_a_valid  output  1  one-cycle strobe: rsp_data belongs to A
- rsp_b_valid  output  1  one-cycle strobe: rsp_data belongs to B
- rsp_data  output  16  product of the retiring op
- busy  output  1  at least one op in flight
- cnt_a  output  CW  number of A issues, saturating
- cnt_b  output  CW  number of B issues, saturating

Behaviour:
- Clock and reset: single clock domain clk. Reset rst is synchronous and active high.
- Reset values: a_ready, b_ready, rsp_a_valid, rsp_b_valid and busy = 0. rsp_data = 0. cnt_a = cnt_b = 0. Pipeline valid/tag bits cleared. Round-robin pointer last = B, so A wins the first tie.
- Reset mid-operation: in-flight ops are discarded and no response is produced for them.
- Ready logic:
  - a_ready and b_ready are combinational from en, a_valid, b_valid and last.
  - At most one ready is high per cycle.
  - A ready is never high while its own valid is low.
- Grant rules:
  - en=0: no grant.
  - Only one requester valid: grant it.
  - Both valid: grant the requester not equal to last.
- Issue and pointer update:
  - Issue occurs when valid&&ready is sampled at a rising edge.
  - On issue, last <= granted requester. last is unchanged when nothing issues.
- Requester rules:
  - A requester must hold valid and operands stable until ready.
  - The arbiter never drops a pending request.
  - No starvation: with both continuously valid, grants alternate A,B,A,B.
- Pipeline:
  - Stage 1 registers x, y and a tag (A/B) plus a valid bit at the issue edge.
  - The product is x*y, unsigned, full 16 bits, no truncation.
  - It is registered through the remaining stages.
- Response timing:
  - For an issue at edge k, the matching rsp_*_valid is high for exactly the one cycle following edge k+LAT-1.
  - With LAT=2, the strobe is high in the cycle after the edge following the issue.
  - rsp_data is valid during that cycle.
- Response strobes:
  - rsp_a_valid and rsp_b_valid are never high together.
  - Back-to-back issues give back-to-back strobes in issue order.
  - There is no response backpressure; requesters must accept the strobe.
- rsp_data holds its last value when no strobe is active.
- busy = OR of all pipeline valid bits, including the output stage.
- en deassertion:
  - en=0 blocks new grants only.
  - In-flight ops complete normally.
  - The pointer is preserved.
- Counters:
  - cnt_a/cnt_b increment by 1 on each A/B issue.
  - They saturate at 2^CW-1 and do not wrap.
- Boundary products: 0xFF*0xFF = 0xFE01. Any operand of 0 gives 0x0000.

Test Plan:
- Reset: drive rst=1 with both valid and en=1 -> both readys 0, all outputs 0, no strobes. Release rst -> A is granted first.
- Single requester:
  - A issues x=0x12, y=0x34 at edge k with LAT=2.
  - rsp_a_valid is high one cycle after edge k+1, with rsp_data=0x03A8.
  - rsp_b_valid stays 0 and busy falls after the strobe.
- Contention: both valid continuously for 6 cycles -> grant order A,B,A,B,A,B. Strobes follow in the same order, back to back. cnt_a=3, cnt_b=3.
- Boundary operands: B issues 0xFF*0xFF, then A issues 0x00*0x7F in consecutive cycles -> rsp_data=0xFE01 tagged B, then 0x0000 tagged A.
- en and reset mid-flight:
  - Deassert en after one issue -> that op still returns and no new grant is made.
  - Assert rst while 2 ops are in flight -> no strobes, busy=0 on the next cycle.
- Saturation: with CW=4, 20 A issues -> cnt_a=15, holding at 15.

Source files
------------

// File: rtl/mul_share_arb.sv
// Round-robin sharing of one unsigned 8x8 multiplier between requesters A and B,
// feeding a LAT-deep registered pipeline with per-requester saturating issue counters.
module mul_share_arb #(
  parameter int LAT = 2,
  parameter int CW  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [7:0]    a_x,
  input  logic [7:0]    a_y,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [7:0]    b_x,
  input  logic [7:0]    b_y,
  output logic          rsp_a_valid,
  output logic          rsp_b_valid,
  output logic [15:0]   rsp_data,
  output logic          busy,
  output logic [CW-1:0] cnt_a,
  output logic [CW-1:0] cnt_b
);

  typedef enum logic {
    LAST_A = 1'b0,
    LAST_B = 1'b1
  } last_t;

  last_t          last_reg;
  last_t          last_next;
  logic           issue;
  logic           grant_b;
  logic [7:0]     issue_x;
  logic [7:0]     issue_y;
  logic [1:0]     issue_vec;
  logic [LAT-1:0] vld_reg;
  logic [LAT-1:0] tag_reg;

  // Arbitration: the requester that did not win last gets priority on a tie.
  always_comb begin
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    last_next = last_reg;
    if (!rst && en) begin
      if (a_valid && (!b_valid || last_reg == LAST_B)) begin
        a_ready = 1'b1;
      end else if (b_valid) begin
        b_ready = 1'b1;
      end
    end
    if (a_ready) begin
      last_next = LAST_A;
    end else if (b_ready) begin
      last_next = LAST_B;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_reg <= LAST_B;
    end else begin
      last_reg <= last_next;
    end
  end

  assign issue     = a_ready | b_ready;
  assign grant_b   = b_ready;
  assign issue_x   = b_ready ? b_x : a_x;
  assign issue_y   = b_ready ? b_y : a_y;
  assign issue_vec = {b_ready, a_ready};

  // Valid/tag shift chain; tag 1 marks an op belonging to B.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_reg <= '0;
      tag_reg <= '0;
    end else begin
      vld_reg[0] <= issue;
      tag_reg[0] <= grant_b;
      for (int i = 1; i < LAT; i++) begin
        vld_reg[i] <= vld_reg[i-1];
        tag_reg[i] <= tag_reg[i-1];
      end
    end
  end

  assign rsp_a_valid = vld_reg[LAT-1] & ~tag_reg[LAT-1];
  assign rsp_b_valid = vld_reg[LAT-1] &  tag_reg[LAT-1];
  assign busy        = |vld_reg;

  // Data stages only load when their feeding stage is valid, so the last
  // stage doubles as the hold register for rsp_data between strobes.
  generate
    if (LAT == 1) begin : g_lat1
      logic [15:0] data_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          data_reg <= '0;
        end else if (issue) begin
          data_reg <= {8'h00, issue_x} * {8'h00, issue_y};
        end
      end
      assign rsp_data = data_reg;
    end else begin : g_latn
      logic [7:0] x_reg;
      logic [7:0] y_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          x_reg <= '0;
          y_reg <= '0;
        end else if (issue) begin
          x_reg <= issue_x;
          y_reg <= issue_y;
        end
      end
      for (genvar gi = 1; gi < LAT; gi++) begin : g_prod
        logic [15:0] prod_reg;
        if (gi == 1) begin : g_first
          always_ff @(posedge clk) begin
            if (rst) begin
              prod_reg <= '0;
            end else if (vld_reg[0]) begin
              prod_reg <= {8'h00, x_reg} * {8'h00, y_reg};
            end
          end
        end else begin : g_rest
          always_ff @(posedge clk) begin
            if (rst) begin
              prod_reg <= '0;
            end else if (vld_reg[gi-1]) begin
              prod_reg <= g_prod[gi-1].prod_reg;
            end
          end
        end
      end
      assign rsp_data = g_prod[LAT-1].prod_reg;
    end
  endgenerate

  // Saturating issue counters, index 0 = A, 1 = B.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CW-1:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (issue_vec[gi] && cnt_reg != {CW{1'b1}}) begin
          cnt_reg <= cnt_reg + {{(CW-1){1'b0}}, 1'b1};
        end
      end
    end
  endgenerate

  assign cnt_a = g_cnt[0].cnt_reg;
  assign cnt_b = g_cnt[1].cnt_reg;

endmodule

// File: tb/tb_mul_share_arb.sv
// Bench for mul_share_arb: directed vector table, hand sequences for en/reset/saturation,
// then constrained-random traffic against a queue-based reference model.
module tb_mul_share_arb;

  localparam int LAT  = 2;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          en;
  logic          a_valid;
  logic          a_ready;
  logic [7:0]    a_x;
  logic [7:0]    a_y;
  logic          b_valid;
  logic          b_ready;
  logic [7:0]    b_x;
  logic [7:0]    b_y;
  logic          rsp_a_valid;
  logic          rsp_b_valid;
  logic [15:0]   rsp_data;
  logic          busy;
  logic [CW-1:0] cnt_a;
  logic [CW-1:0] cnt_b;

  mul_share_arb #(.LAT(LAT), .CW(CW)) dut (
    .clk(clk), .rst(rst), .en(en),
    .a_valid(a_valid), .a_ready(a_ready), .a_x(a_x), .a_y(a_y),
    .b_valid(b_valid), .b_ready(b_ready), .b_x(b_x), .b_y(b_y),
    .rsp_a_valid(rsp_a_valid), .rsp_b_valid(rsp_b_valid), .rsp_data(rsp_data),
    .busy(busy), .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: ops in flight with their age in clock edges since issue.
  typedef struct {
    logic        tag;
    logic [15:0] prod;
    int          age;
  } op_t;

  op_t         pipe_q[$];
  logic        m_last = 1'b1;
  int          m_ca = 0;
  int          m_cb = 0;
  logic [15:0] m_data = 16'h0000;
  logic        acc_a = 1'b0;
  logic        acc_b = 1'b0;

  function automatic void model_ready(output logic ar, output logic br);
    ar = !rst && en && a_valid && (!b_valid || m_last);
    br = !rst && en && b_valid && (!a_valid || !m_last);
  endfunction

  function automatic logic model_strobe(logic tag);
    foreach (pipe_q[i]) if (pipe_q[i].age == LAT && pipe_q[i].tag == tag) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_edge(logic r, logic ar, logic br, logic [7:0] ax, logic [7:0] ay,
                            logic [7:0] bx, logic [7:0] by);
    op_t nq[$];
    op_t o;
    if (r) begin
      pipe_q.delete();
      m_last = 1'b1;
      m_ca   = 0;
      m_cb   = 0;
      m_data = 16'h0000;
      return;
    end
    foreach (pipe_q[i]) begin
      o = pipe_q[i];
      o.age++;
      if (o.age <= LAT) nq.push_back(o);
    end
    if (ar || br) begin
      o.tag  = br;
      o.prod = br ? ({8'h00, bx} * {8'h00, by}) : ({8'h00, ax} * {8'h00, ay});
      o.age  = 1;
      nq.push_back(o);
      m_last = br;
      if (ar && m_ca < MAXC) m_ca++;
      if (br && m_cb < MAXC) m_cb++;
    end
    foreach (nq[i]) if (nq[i].age == LAT) m_data = nq[i].prod;
    pipe_q = nq;
  endtask

  // Advance one clock edge, keeping the model in step with the DUT.
  task automatic step_edge();
    logic ar, br, r;
    logic [7:0] ax, ay, bx, by;
    model_ready(ar, br);
    r = rst; ax = a_x; ay = a_y; bx = b_x; by = b_y;
    @(posedge clk);
    if (!r && (ar || br))
      $display("issue %s x=%02h y=%02h at %0t", br ? "B" : "A", br ? bx : ax, br ? by : ay, $time);
    model_edge(r, ar, br, ax, ay, bx, by);
    acc_a = ar;
    acc_b = br;
    #1;
  endtask

  task automatic check_model();
    logic ar, br;
    model_ready(ar, br);
    chk("rnd a_ready", 32'(a_ready), 32'(ar));
    chk("rnd b_ready", 32'(b_ready), 32'(br));
    chk("rnd rsp_a_valid", 32'(rsp_a_valid), 32'(model_strobe(1'b0)));
    chk("rnd rsp_b_valid", 32'(rsp_b_valid), 32'(model_strobe(1'b1)));
    chk("rnd rsp_data", 32'(rsp_data), 32'(m_data));
    chk("rnd busy", 32'(busy), 32'(pipe_q.size() != 0));
    chk("rnd cnt_a", 32'(cnt_a), 32'(m_ca));
    chk("rnd cnt_b", 32'(cnt_b), 32'(m_cb));
  endtask

  task automatic set_in(logic r, logic e, logic av, logic [7:0] ax, logic [7:0] ay,
                        logic bv, logic [7:0] bx, logic [7:0] by);
    rst = r; en = e; a_valid = av; a_x = ax; a_y = ay; b_valid = bv; b_x = bx; b_y = by;
  endtask

  typedef struct {
    logic        rst, en, av;
    logic [7:0]  ax, ay;
    logic        bv;
    logic [7:0]  bx, by;
    logic        ar, br, rva, rvb;
    logic [15:0] data;
    logic        busy;
    logic [3:0]  ca, cb;
  } vec_t;

  vec_t vec [20];

  function automatic logic [7:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 8'h00;
      1:       return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    //          rst en av ax     ay     bv bx     by      ar br rva rvb data      busy ca cb
    vec[0]  = '{1, 1, 1, 8'h12, 8'h34, 1, 8'h07, 8'h09,  0, 0, 0, 0, 16'h0000, 0, 0, 0};
    vec[1]  = '{0, 1, 1, 8'h12, 8'h34, 0, 8'h00, 8'h00,  1, 0, 0, 0, 16'h0000, 0, 0, 0};
    vec[2]  = '{0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00,  0, 0, 0, 0, 16'h0000, 1, 1, 0};
    vec[3]  = '{0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00,  0, 0, 1, 0, 16'h03A8, 1, 1, 0};
    vec[4]  = '{0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00,  0, 0, 0, 0, 16'h03A8, 0, 1, 0};
    vec[5]  = '{1, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00,  0, 0, 0, 0, 16'h03A8, 0, 1, 0};
    vec[6]  = '{0, 1, 1, 8'h03, 8'h05, 1, 8'h07, 8'h09,  1, 0, 0, 0, 16'h0000, 0, 0, 0};
    vec[7]  = '{0, 1, 1, 8'h03, 8'h05, 1, 8'h07, 8'h09,  0, 1, 0, 0, 16'h0000, 1, 1, 0};
    vec[8]  = '{0, 1, 1, 8'h03, 8'h05, 1, 8'h07, 8'h09,  1, 0, 1, 0, 16'h000F, 1, 1, 1};
    vec[9]  = '{0, 1, 1, 8'h03, 8'h05, 1, 8'h07, 8'h09,  0, 1, 0, 1, 16'h003F, 1, 2, 1};
    vec[10] = '{0, 1, 1, 8'h03, 8'h05, 1, 8'h07, 8'h09,  1, 0, 1, 0, 16'h000F, 1, 2, 2};
    vec[11] = '{0, 1, 1, 8'h03, 8'h05, 1, 8'h07, 8'h09,  0, 1, 0, 1, 16'h003F, 1, 3, 2};
    vec[12] = '{0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00,  0, 0, 1, 0, 16'h000F, 1, 3, 3};
    vec[13] = '{0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00,  0, 0, 0, 1, 16'h003F, 1, 3, 3};
    vec[14] = '{0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00,  0, 0, 0, 0, 16'h003F, 0, 3, 3};
    vec[15] = '{0, 1, 0, 8'h00, 8'h00, 1, 8'hFF, 8'hFF,  0, 1, 0, 0, 16'h003F, 0, 3, 3};
    vec[16] = '{0, 1, 1, 8'h00, 8'h7F, 0, 8'h00, 8'h00,  1, 0, 0, 0, 16'h003F, 1, 3, 4};
    vec[17] = '{0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00,  0, 0, 0, 1, 16'hFE01, 1, 4, 4};
    vec[18] = '{0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00,  0, 0, 1, 0, 16'h0000, 1, 4, 4};
    vec[19] = '{0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00,  0, 0, 0, 0, 16'h0000, 0, 4, 4};

    set_in(1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    step_edge();
    step_edge();

    for (int r = 0; r < 20; r++) begin
      set_in(vec[r].rst, vec[r].en, vec[r].av, vec[r].ax, vec[r].ay, vec[r].bv, vec[r].bx, vec[r].by);
      @(negedge clk);
      chk($sformatf("row%0d a_ready", r), 32'(a_ready), 32'(vec[r].ar));
      chk($sformatf("row%0d b_ready", r), 32'(b_ready), 32'(vec[r].br));
      chk($sformatf("row%0d rsp_a_valid", r), 32'(rsp_a_valid), 32'(vec[r].rva));
      chk($sformatf("row%0d rsp_b_valid", r), 32'(rsp_b_valid), 32'(vec[r].rvb));
      chk($sformatf("row%0d rsp_data", r), 32'(rsp_data), 32'(vec[r].data));
      chk($sformatf("row%0d busy", r), 32'(busy), 32'(vec[r].busy));
      chk($sformatf("row%0d cnt_a", r), 32'(cnt_a), 32'(vec[r].ca));
      chk($sformatf("row%0d cnt_b", r), 32'(cnt_b), 32'(vec[r].cb));
      step_edge();
    end

    // en drop after one issue: op completes, no grants, pointer kept (last = A).
    set_in(0, 1, 1, 8'h02, 8'h03, 0, 8'h00, 8'h00);
    @(negedge clk);
    chk("en issue a_ready", 32'(a_ready), 32'd1);
    step_edge();
    set_in(0, 0, 1, 8'h02, 8'h03, 1, 8'h04, 8'h04);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("en off a_ready", 32'(a_ready), 32'd0);
      chk("en off b_ready", 32'(b_ready), 32'd0);
      chk("en off rsp_a_valid", 32'(rsp_a_valid), 32'(i == 1));
      chk("en off busy", 32'(busy), 32'(i < 2));
      if (i == 1) chk("en off rsp_data", 32'(rsp_data), 32'h0006);
      chk("en off cnt_a", 32'(cnt_a), 32'd5);
      step_edge();
    end
    set_in(0, 1, 1, 8'h02, 8'h03, 1, 8'h04, 8'h04);
    @(negedge clk);
    chk("en back b_ready", 32'(b_ready), 32'd1);
    chk("en back a_ready", 32'(a_ready), 32'd0);
    step_edge();

    // Reset with ops in flight: the A op in stage 1 must never respond.
    set_in(0, 1, 1, 8'h05, 8'h05, 0, 8'h00, 8'h00);
    @(negedge clk);
    chk("mid a_ready", 32'(a_ready), 32'd1);
    step_edge();
    set_in(1, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    @(negedge clk);
    chk("mid rsp_b_valid", 32'(rsp_b_valid), 32'd1);
    chk("mid rsp_data", 32'(rsp_data), 32'h0010);
    chk("mid busy", 32'(busy), 32'd1);
    step_edge();
    set_in(0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("post rst rsp_a_valid", 32'(rsp_a_valid), 32'd0);
      chk("post rst rsp_b_valid", 32'(rsp_b_valid), 32'd0);
      chk("post rst busy", 32'(busy), 32'd0);
      chk("post rst rsp_data", 32'(rsp_data), 32'h0000);
      chk("post rst cnt_b", 32'(cnt_b), 32'd0);
      step_edge();
    end

    // Saturation: 20 A issues on a 4-bit counter.
    set_in(0, 1, 1, 8'h01, 8'h01, 0, 8'h00, 8'h00);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("sat a_ready", 32'(a_ready), 32'd1);
      chk("sat cnt_a", 32'(cnt_a), 32'((i < 15) ? i : 15));
      step_edge();
    end
    set_in(0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    @(negedge clk);
    chk("sat cnt_a hold", 32'(cnt_a), 32'd15);
    chk("sat cnt_b", 32'(cnt_b), 32'd0);
    step_edge();

    // Random traffic against the model; requesters hold until accepted.
    set_in(1, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    step_edge();
    rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!a_valid || acc_a) begin
        a_valid = ($urandom_range(0, 99) < 65);
        a_x = rnd_op();
        a_y = rnd_op();
      end
      if (!b_valid || acc_b) begin
        b_valid = ($urandom_range(0, 99) < 65);
        b_x = rnd_op();
        b_y = rnd_op();
      end
      en  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 99) == 0);
      @(negedge clk);
      check_model();
      step_edge();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
